// File: rtl/mux_pkg.sv
// mux_pkg: shared types and helpers for the pipe_mux_sel select stage.
// Holds the occupancy state encoding, the select-width helper and the
// fill value used for out-of-range selections.
package mux_pkg;

  // Occupancy of the output stage: nothing held, out register only, out + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Bit fill used for the selected item when sel points past the last input.
  localparam logic ZERO_DATA = 1'b0;

  // Width of the select index for a given input count, never narrower than 1.
  function automatic int sel_width(input int numIn);
    return (numIn <= 2) ? 1 : $clog2(numIn);
  endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// mux_sel_comb: purely combinational N-way select.
// An index at or beyond NUM_IN yields an all-zero item rather than holding.
module mux_sel_comb
  import mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [WIDTH-1:0]        item_o
);

  // Scan every input slot; only a matching in-range index overrides the zero default.
  always_comb begin
    item_o = {WIDTH{ZERO_DATA}};
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel_i == SEL_W'(i)) begin
        item_o = in_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/pipe_mux_sel.sv
// pipe_mux_sel: N-way WIDTH-bit select with a registered output, valid/ready
// handshake and a 2-entry (out + skid) buffer so back-pressure never drops
// or reorders items. flush discards everything held, synchronously.
// Optional feature macro: PIPE_MUX_SEL_CHECK_EN enables the sticky sel_err
// out-of-range flag and an X-check assertion on sel; otherwise sel_err is 0.
module pipe_mux_sel
  import mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_err
);

  state_e           state_q;
  logic [WIDTH-1:0] outData_q;
  logic [WIDTH-1:0] skidData_q;
  logic             outValid_q;
  logic             inReady_q;
  logic [WIDTH-1:0] item;
  logic             accept;
  logic             consume;

  mux_sel_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .in_data_i (in_data),
    .sel_i     (sel),
    .item_o    (item)
  );

  assign accept    = in_valid & inReady_q;
  assign consume   = outValid_q & out_ready;
  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;

  // Occupancy FSM; in_ready/out_valid are registered alongside the state so neither depends combinationally on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      outData_q  <= '0;
      skidData_q <= '0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
    end else if (flush) begin
      state_q    <= EMPTY;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q    <= ONE;
            outData_q  <= item;
            outValid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            outData_q <= item;
          end else if (accept) begin
            state_q    <= FULL;
            skidData_q <= item;
            inReady_q  <= 1'b0;
          end else if (consume) begin
            state_q    <= EMPTY;
            outValid_q <= 1'b0;
          end
        end
        FULL: begin
          if (consume) begin
            state_q   <= ONE;
            outData_q <= skidData_q;
            inReady_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_MUX_SEL_CHECK_EN
  logic selErr_q;
  logic selOor;

  assign selOor  = (int'(sel) >= NUM_IN);
  assign sel_err = selErr_q;

  // Sticky out-of-range flag: set by any accepted out-of-range select, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      selErr_q <= 1'b0;
    end else if (accept && selOor) begin
      selErr_q <= 1'b1;
    end
  end

  // An offered select must always be a known value.
  assert property (@(posedge clk) disable iff (rst) in_valid |-> !$isunknown(sel));
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_mux_sel.sv
// tb_pipe_mux_sel: drives an 8-input and a 5-input pipe_mux_sel with the same
// handshake stimulus. A queue model of the held items is checked every cycle,
// and hand-computed literals pin specific scenarios.
module tb_pipe_mux_sel;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] inData;
  logic [2:0]   sel;
  logic         inValid;
  logic         outReady;
  logic         flush;

  logic         inReady8, outValid8, selErr8;
  logic [31:0]  outData8;
  logic         inReady5, outValid5, selErr5;
  logic [31:0]  outData5;

  int           total = 0;
  int           bad = 0;
  bit           checkEn = 1'b0;
  logic [31:0]  q8[$];
  logic [31:0]  q5[$];
  bit           errSticky5 = 1'b0;

`ifdef PIPE_MUX_SEL_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  pipe_mux_sel #(.WIDTH(32), .NUM_IN(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (inData),
    .sel       (sel),
    .in_valid  (inValid),
    .in_ready  (inReady8),
    .out_data  (outData8),
    .out_valid (outValid8),
    .out_ready (outReady),
    .flush     (flush),
    .sel_err   (selErr8)
  );

  pipe_mux_sel #(.WIDTH(32), .NUM_IN(5)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (inData[5*32-1:0]),
    .sel       (sel),
    .in_valid  (inValid),
    .in_ready  (inReady5),
    .out_data  (outData5),
    .out_valid (outValid5),
    .out_ready (outReady),
    .flush     (flush),
    .sel_err   (selErr5)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // One comparison: count it, and report it if the value is wrong.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    return inData[i*32 +: 32];
  endfunction

  task automatic setWord(input int i, input logic [31:0] v);
    inData[i*32 +: 32] = v;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] s, input logic r, input logic f);
    inValid  = v;
    sel      = s;
    outReady = r;
    flush    = f;
  endtask

  // Advance one clock edge and update the queue model from the inputs seen at that edge.
  task automatic stepCycle();
    bit acc;
    bit cons;
    @(posedge clk);
    if (!rst) begin
      acc  = inValid && (q8.size() < 2);
      cons = (q8.size() != 0) && outReady;
      if (acc && int'(sel) >= 5) errSticky5 = 1'b1;
      if (flush) begin
        q8.delete();
        q5.delete();
      end else begin
        if (cons) begin
          void'(q8.pop_front());
          void'(q5.pop_front());
        end
        if (acc) begin
          q8.push_back(word(int'(sel)));
          q5.push_back((int'(sel) < 5) ? word(int'(sel)) : 32'h0);
        end
      end
    end
    #1;
  endtask

  // Every cycle, compare both DUTs against the queue model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("valid8", 32'(outValid8), 32'(q8.size() != 0));
      checkOutput("ready8", 32'(inReady8), 32'(q8.size() < 2));
      if (q8.size() != 0) checkOutput("data8", outData8, q8[0]);
      checkOutput("err8", 32'(selErr8), 32'h0);
      checkOutput("valid5", 32'(outValid5), 32'(q5.size() != 0));
      checkOutput("ready5", 32'(inReady5), 32'(q5.size() < 2));
      if (q5.size() != 0) checkOutput("data5", outData5, q5[0]);
      checkOutput("err5", 32'(selErr5), 32'(CHECK_ON & errSticky5));
    end
  end

  initial begin
    rst    = 1'b1;
    inData = '0;
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    #12;
    checkOutput("rst_valid", 32'(outValid8), 32'h0);
    checkOutput("rst_ready", 32'(inReady8), 32'h1);
    checkOutput("rst_data", outData8, 32'h0);
    checkOutput("rst_err", 32'(selErr5), 32'h0);
    rst     = 1'b0;
    checkEn = 1'b1;

    // Single item through input 3.
    setWord(3, 32'hDEADBEEF);
    applyStimulus(1'b1, 3'd3, 1'b1, 1'b0);
    stepCycle();
    checkOutput("single_data8", outData8, 32'hDEADBEEF);
    checkOutput("single_data5", outData5, 32'hDEADBEEF);
    checkOutput("single_valid", 32'(outValid8), 32'h1);
    checkOutput("single_ready", 32'(inReady8), 32'h1);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("single_drain", 32'(outValid8), 32'h0);

    // Back-pressure fills the skid; A then B drain in order.
    setWord(0, 32'h11);
    setWord(1, 32'h22);
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("bp_full_ready", 32'(inReady8), 32'h0);
    checkOutput("bp_a", outData8, 32'h11);
    setWord(1, 32'hFF);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("bp_b", outData8, 32'h22);
    checkOutput("bp_ready", 32'(inReady8), 32'h1);
    stepCycle();
    checkOutput("bp_empty", 32'(outValid8), 32'h0);

    // Streaming: 16 back-to-back items cycling sel 0..7.
    for (int i = 0; i < 16; i++) begin
      setWord(i % 8, 32'h1000_0000 + 32'(i));
      applyStimulus(1'b1, 3'(i % 8), 1'b1, 1'b0);
      stepCycle();
      checkOutput("stream_data8", outData8, 32'h1000_0000 + 32'(i));
    end
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    stepCycle();

    // Out-of-range select on the 5-input instance, then flush.
    setWord(6, 32'h66);
    applyStimulus(1'b1, 3'd6, 1'b1, 1'b0);
    stepCycle();
    checkOutput("oor_data5", outData5, 32'h0);
    checkOutput("oor_data8", outData8, 32'h66);
    checkOutput("oor_err5", 32'(selErr5), 32'(CHECK_ON));
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b1);
    stepCycle();
    checkOutput("oor_flush_valid", 32'(outValid5), 32'h0);
    checkOutput("oor_err_sticky", 32'(selErr5), 32'(CHECK_ON));

    // Flush while FULL with in_valid and out_ready high.
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("fl_full_ready", 32'(inReady8), 32'h0);
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
    stepCycle();
    checkOutput("fl_valid", 32'(outValid8), 32'h0);
    checkOutput("fl_ready", 32'(inReady8), 32'h1);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("fl_quiet", 32'(outValid8), 32'h0);
    end

    // Asynchronous reset mid-cycle while holding one item.
    applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
    stepCycle();
    checkOutput("ar_one", 32'(outValid8), 32'h1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    q8.delete();
    q5.delete();
    errSticky5 = 1'b0;
    #1;
    checkOutput("ar_valid", 32'(outValid8), 32'h0);
    checkOutput("ar_ready", 32'(inReady8), 32'h1);
    checkOutput("ar_valid5", 32'(outValid5), 32'h0);
    checkOutput("ar_err5", 32'(selErr5), 32'h0);
    #3;
    rst = 1'b0;

    // Recovery after reset.
    applyStimulus(1'b1, 3'd4, 1'b1, 1'b0);
    stepCycle();
    checkOutput("rec_data8", outData8, 32'h1000_000C);
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    stepCycle();
    stepCycle();

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
